// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder
//
// Slave end of the core's instruction fetch bus. Fetch requests are granted
// against an outstanding-request limit and an external stall, the on-chip SRAM
// is read on each accepted request, and responses come back in acceptance
// order exactly Latency cycles after the grant. The SRAM is loaded through a
// byte-enabled backdoor write port and is never reset.
//
// Optional feature macro: IBEX_INSTR_RESP_ERR_EN
//   defined   : misaligned or out-of-range fetches return err=1, rdata=0 and
//               do not read the SRAM.
//   undefined : address bits [1:0] are ignored, addresses wrap modulo
//               MemWords, instr_err_o stays 0.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   instr_req_i      fetch request
//   instr_addr_i     fetch byte address
//   instr_gnt_o      request accepted this cycle (combinational)
//   instr_rvalid_o   response valid
//   instr_rdata_o    response data (holds last value while rvalid is low)
//   instr_err_o      response is a bus error (holds last value likewise)
//   stall_i          withhold grants this cycle
//   wr_en_i          backdoor write strobe
//   wr_addr_i        backdoor word index
//   wr_data_i        backdoor write data
//   wr_be_i          backdoor byte enables
//   busy_o           at least one request is granted but unanswered

module ibex_instr_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        stall_i,
    input  logic                        wr_en_i,
    input  logic [$clog2(MemWords)-1:0] wr_addr_i,
    input  logic [31:0]                 wr_data_i,
    input  logic [3:0]                  wr_be_i,
    output logic                        busy_o
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]     mem [MemWords];

    logic [31:0]     offset;
    logic [IdxW-1:0] rd_idx;
    logic            addr_err;
    logic            accept;
    logic [CntW-1:0] outstanding;

    logic [Latency-1:0] vld_pipe;
    logic [Latency-1:0] err_pipe;
    logic [31:0]        dat_pipe [Latency];

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] rdata_q;
    logic        err_q;

    // Subtraction wraps in 32 bits so addresses below BaseAddr alias upward.
    assign offset = instr_addr_i - BaseAddr;
    assign rd_idx = offset[IdxW+1:2];

`ifdef IBEX_INSTR_RESP_ERR_EN
    assign addr_err = (instr_addr_i[1:0] != 2'b00) || (offset >= 32'(4 * MemWords));
`else
    assign addr_err = 1'b0;
`endif

    // Bits dropped by the word-index slice, collected to document that they
    // are intentionally ignored in the wrapping build.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[1:0], offset[31:IdxW+2]};

    // The limit is checked against the registered count only, so a response
    // retiring this cycle does not free a slot until the next cycle.
    assign instr_gnt_o = rst_ni & instr_req_i & ~stall_i
                       & (outstanding < CntW'(MaxOutstanding));
    assign accept      = instr_req_i & instr_gnt_o;

    assign rsp_valid = vld_pipe[Latency-1];
    assign rsp_err   = err_pipe[Latency-1];
    assign rsp_data  = rsp_err ? 32'h0 : dat_pipe[Latency-1];

    // Control side of the response pipeline plus the output hold registers;
    // everything here is cleared by reset so in-flight responses are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe    <= '0;
            err_pipe    <= '0;
            outstanding <= '0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            vld_pipe[0] <= accept;
            err_pipe[0] <= accept & addr_err;
            for (int k = 1; k < Latency; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                err_pipe[k] <= err_pipe[k-1];
            end
            case ({accept, rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (rsp_valid) begin
                rdata_q <= rsp_data;
                err_q   <= rsp_err;
            end
        end
    end

    // SRAM and data side of the pipeline. Stage 0 is the synchronous read
    // register; a read that collides with a backdoor write sees the old word
    // because both use non-blocking updates on the same edge.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
        if (accept && !addr_err) begin
            dat_pipe[0] <= mem[rd_idx];
        end
        for (int k = 1; k < Latency; k++) begin
            dat_pipe[k] <= dat_pipe[k-1];
        end
    end

    assign instr_rvalid_o = rsp_valid;
    assign instr_rdata_o  = rsp_valid ? rsp_data : rdata_q;
    assign instr_err_o    = rsp_valid ? rsp_err  : err_q;
    assign busy_o         = (outstanding != '0);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// tb_ibex_instr_mem_responder
//
// Directed bench for ibex_instr_mem_responder built with Latency=2 and
// MaxOutstanding=2, MemWords=1024, BaseAddr=0. Inputs change one time unit
// after each rising edge and outputs are sampled a further time unit later.
// Expectations for the error-response cases follow IBEX_INSTR_RESP_ERR_EN.

module tb_ibex_instr_mem_responder;

    localparam int unsigned MemWords = 1024;

`ifdef IBEX_INSTR_RESP_ERR_EN
    localparam logic        ExpErr  = 1'b1;
    localparam logic [31:0] ExpData = 32'h0000_0000;
`else
    localparam logic        ExpErr  = 1'b0;
    localparam logic [31:0] ExpData = 32'hDEAD_BEEF;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        stall_i;
    logic        wr_en_i;
    logic [9:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_be_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    ibex_instr_mem_responder #(
        .MemWords       (MemWords),
        .BaseAddr       (32'h0000_0000),
        .Latency        (2),
        .MaxOutstanding (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .stall_i        (stall_i),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .wr_be_i        (wr_be_i),
        .busy_o         (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        wr_be_i   = be;
        step();
        wr_en_i   = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        stall_i      = 1'b0;
        wr_en_i      = 1'b0;
        wr_addr_i    = '0;
        wr_data_i    = 32'h0;
        wr_be_i      = 4'h0;

        // reset state, grant forced low even with req high
        #1;
        check("rst_gnt",    {31'b0, instr_gnt_o},    32'd0);
        check("rst_rvalid", {31'b0, instr_rvalid_o}, 32'd0);
        check("rst_rdata",  instr_rdata_o,           32'h0);
        check("rst_err",    {31'b0, instr_err_o},    32'd0);
        check("rst_busy",   {31'b0, busy_o},         32'd0);
        step();
        step();
        rst_ni      = 1'b1;
        instr_req_i = 1'b0;
        step();

        // preload, including a partial byte-enable write to word 3
        bd_write(10'd0, 32'hDEAD_BEEF, 4'hF);
        bd_write(10'd1, 32'hCAFE_F00D, 4'hF);
        bd_write(10'd2, 32'h0000_0000, 4'hF);
        bd_write(10'd3, 32'h1122_3344, 4'hF);
        bd_write(10'd3, 32'hAABB_CCDD, 4'b0101);

        // single fetch, latency 2, then hold of rdata
        instr_req_i = 1'b1; instr_addr_i = 32'h0; #1;
        check("a_gnt", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0; #1;
        check("a_rv_early", {31'b0, instr_rvalid_o}, 32'd0);
        check("a_busy",     {31'b0, busy_o},         32'd1);
        step(); #1;
        check("a_rv",    {31'b0, instr_rvalid_o}, 32'd1);
        check("a_rdata", instr_rdata_o,           32'hDEAD_BEEF);
        check("a_err",   {31'b0, instr_err_o},    32'd0);
        step(); #1;
        check("a_rv_off", {31'b0, instr_rvalid_o}, 32'd0);
        check("a_hold",   instr_rdata_o,           32'hDEAD_BEEF);
        check("a_idle",   {31'b0, busy_o},         32'd0);

        // outstanding limit with no same-cycle credit reuse
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h0; #1;
        check("b_gnt0", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_addr_i = 32'h4; #1;
        check("b_gnt1", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_addr_i = 32'hC; #1;
        check("b_gnt_limit", {31'b0, instr_gnt_o},    32'd0);
        check("b_rv0",       {31'b0, instr_rvalid_o}, 32'd1);
        check("b_rdata0",    instr_rdata_o,           32'hDEAD_BEEF);
        step(); #1;
        check("b_gnt2",   {31'b0, instr_gnt_o},    32'd1);
        check("b_rv1",    {31'b0, instr_rvalid_o}, 32'd1);
        check("b_rdata1", instr_rdata_o,           32'hCAFE_F00D);
        step(); instr_req_i = 1'b0; #1;
        check("b_gap", {31'b0, instr_rvalid_o}, 32'd0);
        step(); #1;
        check("b_rv2",    {31'b0, instr_rvalid_o}, 32'd1);
        check("b_rdata2", instr_rdata_o,           32'h11BB_33DD);
        step(); #1;
        check("b_idle", {31'b0, busy_o}, 32'd0);

        // stall withholds grants for three cycles
        stall_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("c_stalled", {31'b0, instr_gnt_o}, 32'd0);
            step();
        end
        stall_i = 1'b0; #1;
        check("c_gnt", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0; #1;
        check("c_rv_early", {31'b0, instr_rvalid_o}, 32'd0);
        step(); #1;
        check("c_rv",    {31'b0, instr_rvalid_o}, 32'd1);
        check("c_rdata", instr_rdata_o,           32'hCAFE_F00D);
        step();

        // read and backdoor write of the same word in the same cycle
        instr_req_i = 1'b1; instr_addr_i = 32'h8;
        wr_en_i = 1'b1; wr_addr_i = 10'd2; wr_data_i = 32'h1234_5678; wr_be_i = 4'hF; #1;
        check("d_gnt", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0; wr_en_i = 1'b0;
        step(); #1;
        check("d_rv_old", {31'b0, instr_rvalid_o}, 32'd1);
        check("d_old",    instr_rdata_o,           32'h0000_0000);
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h8; #1;
        check("d_gnt2", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0;
        step(); #1;
        check("d_rv_new", {31'b0, instr_rvalid_o}, 32'd1);
        check("d_new",    instr_rdata_o,           32'h1234_5678);
        step();

        // out-of-range and misaligned addresses
        instr_req_i = 1'b1; instr_addr_i = 32'h1000; #1;
        check("e_gnt0", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_addr_i = 32'h2; #1;
        check("e_gnt1", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0; #1;
        check("e_rv0",    {31'b0, instr_rvalid_o}, 32'd1);
        check("e_err0",   {31'b0, instr_err_o},    {31'b0, ExpErr});
        check("e_rdata0", instr_rdata_o,           ExpData);
        step(); #1;
        check("e_rv1",    {31'b0, instr_rvalid_o}, 32'd1);
        check("e_err1",   {31'b0, instr_err_o},    {31'b0, ExpErr});
        check("e_rdata1", instr_rdata_o,           ExpData);
        step();

        // reset one cycle after an accept drops the response
        instr_req_i = 1'b1; instr_addr_i = 32'h4; #1;
        check("f_gnt", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0; rst_ni = 1'b0; #1;
        check("f_rst_busy",  {31'b0, busy_o},         32'd0);
        check("f_rst_rv",    {31'b0, instr_rvalid_o}, 32'd0);
        check("f_rst_rdata", instr_rdata_o,           32'h0);
        check("f_rst_err",   {31'b0, instr_err_o},    32'd0);
        step(); rst_ni = 1'b1; #1;
        check("f_dropped", {31'b0, instr_rvalid_o}, 32'd0);
        step(); #1;
        check("f_dropped2", {31'b0, instr_rvalid_o}, 32'd0);
        instr_req_i = 1'b1; instr_addr_i = 32'h0; #1;
        check("f_gnt_after", {31'b0, instr_gnt_o}, 32'd1);
        step(); instr_req_i = 1'b0;
        step(); #1;
        check("f_rv",    {31'b0, instr_rvalid_o}, 32'd1);
        check("f_rdata", instr_rdata_o,           32'hDEAD_BEEF);
        step(); #1;
        check("f_idle", {31'b0, busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
